// File: rtl/control_unit.sv
// Access-control FSM: request -> authenticate -> confirm -> commit 35-bit config word.
// Latency: confirm rise in CONFIG commits on that clock; configout/write_en are registered and seen in WRITE.
// No backpressure: write_en is a fire-and-forget one-cycle strobe, and repeated bad credentials lock the unit until reset.
module control_unit #(
   parameter int         CFG_W     = 35,
   parameter logic [1:0] PASSWORD  = 2'b11,
   parameter logic [1:0] SYSKEY    = 2'b11,
   parameter int         MAX_FAILS = 3
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             request,
   input  logic             confirm,
   input  logic [1:0]       password,
   input  logic [1:0]       syskey,
   input  logic [CFG_W-1:0] configin,
   output logic [CFG_W-1:0] configout,
   output logic             write_en,
   output logic [2:0]       dbg_state
);

   localparam int FW = $clog2(MAX_FAILS + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      AUTH   = 3'd1,
      CONFIG = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4,
      DENIED = 3'd5,
      LOCKED = 3'd6,
      UNUSED = 3'd7
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [FW-1:0] fail_cnt;
   logic [FW-1:0] fail_nxt;
   logic          confirm_q;
   logic          conf_rise;
   logic          cred_ok;
   logic          cfg_load;

   // A held confirm yields a single event: only the 0->1 transition counts.
   assign conf_rise = confirm & ~confirm_q;
   assign cred_ok   = (password == PASSWORD) && (syskey == SYSKEY);
   assign dbg_state = state;

   // Next-state, failure counting and configuration-load decision.
   always_comb begin
      next_state = state;
      fail_nxt   = fail_cnt;
      cfg_load   = 1'b0;
      case (state)
         IDLE: begin
            if (request) next_state = AUTH;
         end
         AUTH: begin
            // Dropping request wins over a simultaneous confirm; the attempt is not counted.
            if (!request) begin
               next_state = IDLE;
            end else if (conf_rise) begin
               if (cred_ok) begin
                  next_state = CONFIG;
                  fail_nxt   = '0;
               end else begin
                  if (fail_cnt < FW'(MAX_FAILS)) fail_nxt = fail_cnt + FW'(1);
                  next_state = (fail_nxt == FW'(MAX_FAILS)) ? LOCKED : DENIED;
               end
            end
         end
         CONFIG: begin
            if (!request) begin
               next_state = IDLE;
            end else if (conf_rise) begin
               next_state = WRITE;
               cfg_load   = 1'b1;
            end
         end
         WRITE: begin
            // The commit strobe always completes regardless of request.
            next_state = DONE;
         end
         DONE, DENIED: begin
            if (!request) next_state = IDLE;
         end
         LOCKED: begin
            next_state = LOCKED;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, counters, confirm history and registered outputs.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state     <= IDLE;
         fail_cnt  <= '0;
         confirm_q <= 1'b0;
         write_en  <= 1'b0;
         configout <= '0;
      end else begin
         state     <= next_state;
         fail_cnt  <= fail_nxt;
         confirm_q <= confirm;
         write_en  <= (next_state == WRITE);
         if (cfg_load) configout <= configin;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
module tb_control_unit;

   localparam int CFG_W = 35;

   logic             clk = 1'b0;
   logic             arst;
   logic             request;
   logic             confirm;
   logic [1:0]       password;
   logic [1:0]       syskey;
   logic [CFG_W-1:0] configin;
   logic [CFG_W-1:0] configout;
   logic             write_en;
   logic [2:0]       dbg_state;

   int checks = 0;
   int errors = 0;

   // Transaction-level reference: committed word, consecutive failures, lock flag.
   logic [CFG_W-1:0] m_cfg;
   int               m_fails;
   bit               m_locked;

   always #5 clk = ~clk;

   control_unit dut (
      .clk       (clk),
      .arst      (arst),
      .request   (request),
      .confirm   (confirm),
      .password  (password),
      .syskey    (syskey),
      .configin  (configin),
      .configout (configout),
      .write_en  (write_en),
      .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst     = 1'b0;
      request  = 1'b0;
      confirm  = 1'b0;
      password = 2'b00;
      syskey   = 2'b00;
      configin = '0;
      @(negedge clk);
      arst     = 1'b1;
      m_cfg    = '0;
      m_fails  = 0;
      m_locked = 1'b0;
      tick();
   endtask

   // Outcome of one authentication attempt as seen by the user.
   function automatic logic [2:0] model_auth(input logic [1:0] pw, input logic [1:0] key);
      if (m_locked) return 3'd6;
      if (pw == 2'b11 && key == 2'b11) begin
         m_fails = 0;
         return 3'd2;
      end
      if (m_fails < 3) m_fails++;
      if (m_fails == 3) begin
         m_locked = 1'b1;
         return 3'd6;
      end
      return 3'd5;
   endfunction

   task automatic test_reset();
      arst = 1'b0; request = 1'b0; confirm = 1'b0;
      password = 2'b00; syskey = 2'b00; configin = '0;
      #2;
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      checks++; if (configout !== '0) begin errors++; $display("FAIL reset_configout: got %h want 0", configout); end
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b want 0", write_en); end
      @(negedge clk);
      arst = 1'b1;
      m_cfg = '0; m_fails = 0; m_locked = 1'b0;
      tick();
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_idle_hold: got %0d want 0", dbg_state); end
   endtask

   task automatic test_good();
      logic [2:0]       exp;
      logic [CFG_W-1:0] w;
      w = 35'h2_FFFF_FFFF;
      request = 1'b1; tick();
      checks++; if (dbg_state !== 3'd1) begin errors++; $display("FAIL good_auth: got %0d want 1", dbg_state); end
      password = 2'b11; syskey = 2'b11; confirm = 1'b1; tick();
      exp = model_auth(2'b11, 2'b11);
      checks++; if (dbg_state !== exp) begin errors++; $display("FAIL good_config: got %0d want %0d", dbg_state, exp); end
      confirm = 1'b0; configin = w; tick();
      checks++; if (dbg_state !== 3'd2 || write_en !== 1'b0) begin errors++; $display("FAIL good_wait: state %0d we %b want 2/0", dbg_state, write_en); end
      confirm = 1'b1; tick();
      checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL good_write_state: got %0d want 3", dbg_state); end
      checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL good_write_en: got %b want 1", write_en); end
      checks++; if (configout !== w) begin errors++; $display("FAIL good_configout: got %h want %h", configout, w); end
      m_cfg = w;
      confirm = 1'b0; tick();
      checks++; if (dbg_state !== 3'd4 || write_en !== 1'b0) begin errors++; $display("FAIL good_done: state %0d we %b want 4/0", dbg_state, write_en); end
      request = 1'b0; tick();
      checks++; if (dbg_state !== 3'd0 || configout !== m_cfg) begin errors++; $display("FAIL good_idle: state %0d cfg %h want 0/%h", dbg_state, configout, m_cfg); end
   endtask

   task automatic test_held();
      logic [2:0]       exp;
      logic [CFG_W-1:0] w;
      w = 35'h2_0FFF_FFFF;
      request = 1'b1; tick();
      password = 2'b11; syskey = 2'b11; confirm = 1'b1; tick();
      exp = model_auth(2'b11, 2'b11);
      checks++; if (dbg_state !== exp) begin errors++; $display("FAIL held_config: got %0d want %0d", dbg_state, exp); end
      configin = 35'h1_2345_6789;
      repeat (3) tick();
      checks++; if (dbg_state !== 3'd2 || write_en !== 1'b0 || configout !== m_cfg) begin
         errors++; $display("FAIL held_no_commit: state %0d we %b cfg %h want 2/0/%h", dbg_state, write_en, configout, m_cfg); end
      configin = w; confirm = 1'b0; tick();
      confirm = 1'b1; tick();
      checks++; if (dbg_state !== 3'd3 || write_en !== 1'b1 || configout !== w) begin
         errors++; $display("FAIL held_commit: state %0d we %b cfg %h want 3/1/%h", dbg_state, write_en, configout, w); end
      m_cfg = w;
      confirm = 1'b0; tick();
      checks++; if (dbg_state !== 3'd4 || write_en !== 1'b0) begin errors++; $display("FAIL held_done: state %0d we %b want 4/0", dbg_state, write_en); end
      request = 1'b0; tick();
   endtask

   task automatic test_bad_key();
      logic [2:0] exp;
      request = 1'b1; tick();
      password = 2'b11; syskey = 2'b01; confirm = 1'b1; tick();
      exp = model_auth(2'b11, 2'b01);
      checks++; if (dbg_state !== exp) begin errors++; $display("FAIL bad_key_denied: got %0d want %0d", dbg_state, exp); end
      confirm = 1'b0; tick();
      checks++; if (dbg_state !== 3'd5) begin errors++; $display("FAIL bad_key_hold: got %0d want 5", dbg_state); end
      request = 1'b0; tick();
      checks++; if (dbg_state !== 3'd0 || configout !== m_cfg) begin errors++; $display("FAIL bad_key_idle: state %0d cfg %h want 0/%h", dbg_state, configout, m_cfg); end
   endtask

   task automatic test_abort();
      logic [2:0] exp;
      request = 1'b1; tick();
      password = 2'b00; syskey = 2'b00; confirm = 1'b1; request = 1'b0; tick();
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL abort_auth: got %0d want 0", dbg_state); end
      confirm = 1'b0;
      request = 1'b1; tick();
      password = 2'b11; syskey = 2'b11; confirm = 1'b1; tick();
      exp = model_auth(2'b11, 2'b11);
      checks++; if (dbg_state !== exp) begin errors++; $display("FAIL abort_reach_config: got %0d want %0d", dbg_state, exp); end
      confirm = 1'b0; configin = 35'h5_5555_5555; tick();
      request = 1'b0; confirm = 1'b1; tick();
      checks++; if (dbg_state !== 3'd0 || write_en !== 1'b0) begin errors++; $display("FAIL abort_config: state %0d we %b want 0/0", dbg_state, write_en); end
      confirm = 1'b0; tick();
      checks++; if (write_en !== 1'b0 || configout !== m_cfg) begin errors++; $display("FAIL abort_no_write: we %b cfg %h want 0/%h", write_en, configout, m_cfg); end
   endtask

   task automatic test_reset_mid();
      logic [2:0] exp;
      request = 1'b1; tick();
      password = 2'b11; syskey = 2'b11; confirm = 1'b1; tick();
      exp = model_auth(2'b11, 2'b11);
      confirm = 1'b0;
      arst = 1'b0; #1;
      checks++; if (dbg_state !== 3'd0 || configout !== '0 || write_en !== 1'b0) begin
         errors++; $display("FAIL reset_mid: state %0d cfg %h we %b want 0/0/0 (pre-reset %0d)", dbg_state, configout, write_en, exp); end
      request = 1'b0;
      @(negedge clk);
      arst = 1'b1;
      m_cfg = '0; m_fails = 0; m_locked = 1'b0;
      tick();
   endtask

   task automatic test_fail_clear();
      logic [1:0] pws [5];
      logic [2:0] exp;
      pws = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
      foreach (pws[i]) begin
         request = 1'b1; tick();
         password = pws[i]; syskey = 2'b11; confirm = 1'b1; tick();
         exp = model_auth(pws[i], 2'b11);
         checks++; if (dbg_state !== exp) begin errors++; $display("FAIL fail_clear_%0d: got %0d want %0d", i, dbg_state, exp); end
         confirm = 1'b0; request = 1'b0; tick();
      end
   endtask

   task automatic test_lockout();
      logic [2:0] exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         request = 1'b1; tick();
         password = 2'b01; syskey = 2'b11; confirm = 1'b1; tick();
         exp = model_auth(2'b01, 2'b11);
         checks++; if (dbg_state !== exp) begin errors++; $display("FAIL lockout_try%0d: got %0d want %0d", i, dbg_state, exp); end
         confirm = 1'b0; request = 1'b0; tick();
      end
      request = 1'b1; password = 2'b11; syskey = 2'b11; confirm = 1'b1; tick();
      confirm = 1'b0; configin = 35'h7_FFFF_FFFF; tick();
      confirm = 1'b1; tick();
      checks++; if (dbg_state !== 3'd6 || write_en !== 1'b0 || configout !== '0) begin
         errors++; $display("FAIL lockout_sticky: state %0d we %b cfg %h want 6/0/0", dbg_state, write_en, configout); end
      confirm = 1'b0; request = 1'b0; tick();
      checks++; if (dbg_state !== 3'd6) begin errors++; $display("FAIL lockout_idle_ignored: got %0d want 6", dbg_state); end
      arst = 1'b0; #1;
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL lockout_reset: got %0d want 0", dbg_state); end
      @(negedge clk); arst = 1'b1;
      m_cfg = '0; m_fails = 0; m_locked = 1'b0;
      tick();
      request = 1'b1; tick();
      confirm = 1'b1; tick();
      exp = model_auth(2'b11, 2'b11);
      checks++; if (dbg_state !== exp) begin errors++; $display("FAIL lockout_unlocked: got %0d want %0d", dbg_state, exp); end
      confirm = 1'b0; request = 1'b0; tick();
   endtask

   task automatic test_random();
      for (int s = 0; s < 80; s++) begin
         logic [63:0] r;
         logic [1:0]  pw;
         logic [1:0]  key;
         int          ab;
         logic [2:0]  exp;
         ab = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            pw = 2'b11; key = 2'b11;
         end else begin
            pw = 2'($urandom_range(0, 3)); key = 2'($urandom_range(0, 3));
         end
         r = {$urandom, $urandom};
         request = 1'b1; tick();
         exp = m_locked ? 3'd6 : 3'd1;
         checks++; if (dbg_state !== exp) begin errors++; $display("FAIL rnd%0d_request: got %0d want %0d", s, dbg_state, exp); end
         password = pw; syskey = key; confirm = 1'b1;
         if (ab == 1) begin
            request = 1'b0; tick();
            exp = m_locked ? 3'd6 : 3'd0;
            checks++; if (dbg_state !== exp) begin errors++; $display("FAIL rnd%0d_abort_auth: got %0d want %0d", s, dbg_state, exp); end
            confirm = 1'b0;
         end else begin
            tick();
            exp = model_auth(pw, key);
            checks++; if (dbg_state !== exp) begin errors++; $display("FAIL rnd%0d_auth: got %0d want %0d", s, dbg_state, exp); end
            confirm = 1'b0; configin = r[CFG_W-1:0]; tick();
            if (exp == 3'd2) begin
               if (ab == 2) begin
                  request = 1'b0; confirm = 1'b1; tick();
                  checks++; if (dbg_state !== 3'd0 || write_en !== 1'b0) begin
                     errors++; $display("FAIL rnd%0d_abort_cfg: state %0d we %b want 0/0", s, dbg_state, write_en); end
                  confirm = 1'b0;
               end else begin
                  confirm = 1'b1; tick();
                  checks++; if (dbg_state !== 3'd3 || write_en !== 1'b1 || configout !== r[CFG_W-1:0]) begin
                     errors++; $display("FAIL rnd%0d_commit: state %0d we %b cfg %h want 3/1/%h", s, dbg_state, write_en, configout, r[CFG_W-1:0]); end
                  m_cfg = r[CFG_W-1:0];
                  confirm = 1'b0; tick();
                  checks++; if (dbg_state !== 3'd4 || write_en !== 1'b0) begin
                     errors++; $display("FAIL rnd%0d_done: state %0d we %b want 4/0", s, dbg_state, write_en); end
               end
            end
            request = 1'b0; tick();
            exp = m_locked ? 3'd6 : 3'd0;
            checks++; if (dbg_state !== exp || configout !== m_cfg) begin
               errors++; $display("FAIL rnd%0d_end: state %0d cfg %h want %0d/%h", s, dbg_state, configout, exp, m_cfg); end
         end
         if (m_locked && $urandom_range(0, 2) == 0) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_good();
      test_held();
      test_bad_key();
      test_abort();
      test_reset_mid();
      test_fail_clear();
      test_lockout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
